shufflev_issue_buffer: RTL and testbench

SHUFFLEV_ISSUE_BUFFER -- requirements
Module: shufflev_issue_buffer

---
 rtl/shufflev_issue_buffer.sv | 136 +++++++++++++
 tb/tb_shufflev_issue_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shufflev_issue_buffer.sv
// Age-ordered issue buffer: offers a pseudo-random older entry (SHUFFLEV_RANDOM_EN) or strictly entry 0.
// Latency: an accepted entry is first offerable one cycle after its accept; no pass-through.
// Backpressure: offer is held while out_ready low; in_ready drops on flush, full (unless issuing), stored barrier.
module shufflev_issue_buffer #(
  parameter int unsigned DEPTH     = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_rdata_i,
  input  logic [31:0]                in_addr_i,
  input  logic                       in_barrier_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_rdata_o,
  output logic [31:0]                out_addr_o,
  input  logic                       reseed_valid_i,
  input  logic [15:0]                reseed_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic        barrier;
    logic [31:0] addr;
    logic [31:0] rdata;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic          held_q;
  logic [IW-1:0] held_idx_q;

  logic          bar_found;
  logic [IW-1:0] bar_idx;
  logic [CW-1:0] cand;
  logic [IW-1:0] base_sel;
  logic [IW-1:0] sel;
  logic          accept;
  logic          issue;
  logic [CW-1:0] wr_idx;
  entry_t        new_entry;

  // Find the oldest stored barrier; it bounds how far back the selector may reach.
  always_comb begin
    bar_found = 1'b0;
    bar_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!bar_found && (CW'(i) < count_q) && mem_q[i].barrier) begin
        bar_found = 1'b1;
        bar_idx   = IW'(i);
      end
    end
  end

  // A barrier at the head is the only candidate; otherwise only entries older than it compete.
  assign cand = !bar_found       ? count_q :
                (bar_idx == '0)  ? CW'(1)  : CW'(bar_idx);

`ifdef SHUFFLEV_RANDOM_EN
  logic [15:0] lfsr_q;
  logic [7:0]  cand8;

  assign cand8    = 8'(cand);
  assign base_sel = (cand == '0) ? '0 : IW'(lfsr_q[7:0] % cand8);

  // Galois LFSR: a nonzero reseed wins over the per-issue advance; flush leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else if (reseed_valid_i && (reseed_i != 16'h0000)) begin
      lfsr_q <= reseed_i;
    end else if (issue) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  logic unused_cfg;

  // Strict FIFO: the head is always the offered entry and the seed inputs are ignored.
  assign base_sel   = '0;
  assign unused_cfg = ^{reseed_valid_i, reseed_i, LFSR_SEED, cand};
`endif

  assign sel         = held_q ? held_idx_q : base_sel;
  assign out_valid_o = (count_q != '0) && !flush_i;
  assign issue       = out_valid_o && out_ready_i;
  // A full buffer still takes a new entry in the same cycle one leaves, keeping a full stream at one per cycle.
  assign in_ready_o  = !flush_i && !bar_found && ((count_q < CW'(DEPTH)) || issue);
  assign accept      = in_valid_i && in_ready_o;
  assign wr_idx      = count_q - CW'(issue);
  assign out_rdata_o = mem_q[sel].rdata;
  assign out_addr_o  = mem_q[sel].addr;
  assign count_o     = count_q;
  assign new_entry   = '{barrier: in_barrier_i, addr: in_addr_i, rdata: in_rdata_i};

  // Occupancy and held selection; flush overrides any same-cycle accept or issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      held_q     <= 1'b0;
      held_idx_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
      held_q  <= 1'b0;
    end else begin
      count_q <= count_q + CW'(accept) - CW'(issue);
      if (issue) begin
        held_q <= 1'b0;
      end else if (out_valid_o) begin
        held_q     <= 1'b1;
        held_idx_q <= sel;
      end
    end
  end

  // Payload storage: close the gap left by an issue, then append the new entry after the shift.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (issue && (IW'(i) >= sel)) begin
        mem_q[i] <= mem_q[i+1];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (accept && (CW'(i) == wr_idx)) begin
        mem_q[i] <= new_entry;
      end
    end
  end

endmodule

// File: tb/tb_shufflev_issue_buffer.sv
// Self-checking bench for shufflev_issue_buffer: directed scenarios plus a randomized run
// against a queue-based reference model; works for both the FIFO and the random-select build.
module tb_shufflev_issue_buffer;

  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef SHUFFLEV_RANDOM_EN
  localparam bit RANDOM_MODE = 1'b1;
`else
  localparam bit RANDOM_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_rdata = '0;
  logic [31:0]   in_addr = '0;
  logic          in_barrier = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_rdata;
  logic [31:0]   out_addr;
  logic          reseed_valid = 1'b0;
  logic [15:0]   reseed = '0;
  logic [CW-1:0] count;

  int nvec = 0;
  int nerr = 0;

  shufflev_issue_buffer #(.DEPTH(DEPTH), .LFSR_SEED(16'hACE1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_rdata_i     (in_rdata),
    .in_addr_i      (in_addr),
    .in_barrier_i   (in_barrier),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_rdata_o    (out_rdata),
    .out_addr_o     (out_addr),
    .reseed_valid_i (reseed_valid),
    .reseed_i       (reseed),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          bar;
  } ent_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] half;
    half = v / 16'd2;
    return (v % 16'd2 == 16'd1) ? (half ^ 16'hB400) : half;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic b);
    in_valid   = 1'b1;
    in_addr    = a;
    in_rdata   = a ^ 32'hDEAD_0000;
    in_barrier = b;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_barrier   = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    reseed_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL reset_count: got %0d want 0", count); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hold();
    idle();
    for (int k = 0; k < 4; k++) begin
      push(32'h1000 + 32'(4 * k), 1'b0);
      #1;
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL hold_in_ready[%0d]: got %b want 1", k, in_ready); end
      if (k > 0) begin
        nvec++; if (out_addr !== 32'h1000) begin nerr++; $display("FAIL hold_stable[%0d]: got %h want 00001000", k, out_addr); end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    nvec++; if (count !== CW'(4)) begin nerr++; $display("FAIL hold_count: got %0d want 4", count); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL hold_ready_end: got %b want 1", in_ready); end
    nvec++; if (out_rdata !== (32'h1000 ^ 32'hDEAD_0000)) begin nerr++; $display("FAIL hold_rdata: got %h want %h", out_rdata, 32'h1000 ^ 32'hDEAD_0000); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL hold_flush_count: got %0d want 0", count); end
  endtask

  task automatic test_midop_reset();
    idle();
    push(32'h2000, 1'b0); tick();
    push(32'h2004, 1'b0); tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL midop_reset_count: got %0d want 0", count); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midop_reset_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_seed();
    logic [31:0] exp2, exp3;
`ifdef SHUFFLEV_RANDOM_EN
    exp2 = 32'h108; exp3 = 32'h104;
`else
    exp2 = 32'h104; exp3 = 32'h108;
`endif
    idle();
    reseed_valid = 1'b1;
    reseed       = 16'h0003;
    tick();
    reseed_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(32'h100 + 32'(4 * k), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    nvec++; if (count !== CW'(3)) begin nerr++; $display("FAIL seed_count: got %0d want 3", count); end
    nvec++; if (out_addr !== 32'h100) begin nerr++; $display("FAIL seed_first: got %h want 00000100", out_addr); end
    out_ready = 1'b1;
    tick();
    nvec++; if (out_addr !== exp2) begin nerr++; $display("FAIL seed_second: got %h want %h", out_addr, exp2); end
    tick();
    nvec++; if (out_addr !== exp3) begin nerr++; $display("FAIL seed_third: got %h want %h", out_addr, exp3); end
    tick();
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL seed_drain: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_barrier();
    idle();
    push(32'h200, 1'b0); tick();
    push(32'h204, 1'b1); tick();
    push(32'h208, 1'b0);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bar_block0: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bar_block1: got %b want 0", in_ready); end
    nvec++; if (count !== CW'(2)) begin nerr++; $display("FAIL bar_count: got %0d want 2", count); end
    out_ready = 1'b1;
    #1;
    nvec++; if (out_addr !== 32'h200) begin nerr++; $display("FAIL bar_first: got %h want 00000200", out_addr); end
    tick();
    nvec++; if (out_addr !== 32'h204) begin nerr++; $display("FAIL bar_second: got %h want 00000204", out_addr); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bar_block2: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bar_release: got %b want 1", in_ready); end
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL bar_empty: got %0d want 0", count); end
    tick();
    in_valid = 1'b0;
    #1;
    nvec++; if (out_addr !== 32'h208) begin nerr++; $display("FAIL bar_third: got %h want 00000208", out_addr); end
    tick();
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL bar_drain: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      push(32'h300 + 32'(4 * k), 1'b0);
      tick();
    end
    #1;
    nvec++; if (count !== CW'(DEPTH)) begin nerr++; $display("FAIL stream_full: got %0d want %0d", count, DEPTH); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stream_full_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(32'h400 + 32'(4 * k), 1'b0);
      #1;
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL stream_ready[%0d]: got %b want 1", k, in_ready); end
      nvec++; if (count !== CW'(DEPTH)) begin nerr++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, count, DEPTH); end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) tick();
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL stream_drain: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 3; k++) begin
      push(32'h500 + 32'(4 * k), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    nvec++; if (count !== CW'(3)) begin nerr++; $display("FAIL flush_pre: got %0d want 3", count); end
    flush     = 1'b1;
    out_ready = 1'b1;
    push(32'h600, 1'b0);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    idle();
    #1;
    nvec++; if (count !== CW'(0)) begin nerr++; $display("FAIL flush_count: got %0d want 0", count); end
  endtask

`ifndef SHUFFLEV_RANDOM_EN
  task automatic test_fifo_order();
    logic [31:0] want [3];
    want[0] = 32'h10; want[1] = 32'h14; want[2] = 32'h18;
    idle();
    for (int k = 0; k < 3; k++) begin
      push(want[k], 1'b0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++; if (out_addr !== want[k]) begin nerr++; $display("FAIL fifo_order[%0d]: got %h want %h", k, out_addr, want[k]); end
      tick();
    end
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    ent_t        q[$];
    bit          held;
    int          hidx;
    logic [15:0] m_lfsr;
    int          n, bidx, c, s;
    bit          e_valid, e_issue, e_ready;

    idle();
    flush        = 1'b1;
    reseed_valid = 1'b1;
    reseed       = 16'h1D2B;
    tick();
    idle();
    held   = 1'b0;
    hidx   = 0;
    m_lfsr = 16'h1D2B;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_addr      = $urandom;
      in_rdata     = $urandom;
      in_barrier   = ($urandom_range(0, 9) == 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      reseed_valid = ($urandom_range(0, 15) == 0);
      reseed       = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      #1;

      n    = q.size();
      bidx = -1;
      foreach (q[i]) if (q[i].bar && bidx < 0) bidx = i;
      c = (bidx < 0) ? n : ((bidx == 0) ? 1 : bidx);
      if (held)                   s = hidx;
      else if (RANDOM_MODE && c > 0) s = int'(m_lfsr[7:0]) % c;
      else                        s = 0;
      e_valid = (n > 0) && !flush;
      e_issue = e_valid && out_ready;
      e_ready = !flush && (bidx < 0) && ((n < DEPTH) || e_issue);

      nvec++; if (out_valid !== e_valid) begin nerr++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, e_valid); end
      nvec++; if (in_ready !== e_ready) begin nerr++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, e_ready); end
      nvec++; if (count !== CW'(n)) begin nerr++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, n); end
      if (e_valid) begin
        nvec++; if (out_addr !== q[s].addr) begin nerr++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, out_addr, q[s].addr); end
        nvec++; if (out_rdata !== q[s].rdata) begin nerr++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, out_rdata, q[s].rdata); end
      end

      if (flush) begin
        q.delete();
        held = 1'b0;
      end else begin
        if (e_issue) begin
          q.delete(s);
          held = 1'b0;
        end else if (e_valid) begin
          held = 1'b1;
          hidx = s;
        end
        if (in_valid && e_ready) q.push_back('{addr: in_addr, rdata: in_rdata, bar: in_barrier});
      end
      if (reseed_valid && reseed != 16'h0000) m_lfsr = reseed;
      else if (e_issue)                       m_lfsr = lfsr_step(m_lfsr);
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_hold();
    test_midop_reset();
    test_seed();
    test_barrier();
    test_stream();
    test_flush();
`ifndef SHUFFLEV_RANDOM_EN
    test_fifo_order();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
